store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer_if.sv | 35 +++
 rtl/store_write_buffer.sv | 114 +++++++++++
 tb/tb_store_write_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// Store-buffer bus: request side from the core, write side toward the
// 32-word data RAM, plus occupancy status.
interface store_write_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_size;
    logic [31:0]      req_addr;
    logic [31:0]      req_data;
    logic             req_err;
    logic             mem_we;
    logic             mem_ready;
    logic [4:0]       mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;

    // Requester / RAM side: drives stores and RAM acceptance.
    modport master (
        output req_valid, req_size, req_addr, req_data, mem_ready,
        input  req_ready, req_err, mem_we, mem_addr, mem_wdata, mem_be,
               buf_count, buf_empty
    );

    // Buffer side.
    modport slave (
        input  req_valid, req_size, req_addr, req_data, mem_ready,
        output req_ready, req_err, mem_we, mem_addr, mem_wdata, mem_be,
               buf_count, buf_empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: validates and lane-encodes byte/halfword/word stores,
// queues them in a DEPTH-entry FIFO, and drains the head toward the data RAM.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    store_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;

    logic [4:0]  addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [3:0]  be_q    [DEPTH];

    logic        ready;
    logic        empty;
    logic        handshake;
    logic        legal;
    logic        push;
    logic        pop;
    logic [31:0] enc_wdata;
    logic [3:0]  enc_be;

    // Alignment and range check; reserved size is always illegal.
    function automatic logic is_legal(input logic [1:0] size, input logic [31:0] addr);
        logic ok;
        ok = (addr[31:7] == 25'd0);
        case (size)
            2'b00:   ok = ok;
            2'b01:   if (addr[0]) ok = 1'b0;
            2'b10:   if (addr[1:0] != 2'b00) ok = 1'b0;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate the right-justified store data across the byte lanes.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Byte enables for the addressed lanes.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Handshake decode; ready looks only at occupancy, never at mem_ready.
    always_comb begin
        ready     = (count < FULL_CNT);
        empty     = (count == '0);
        handshake = bus.req_valid && ready;
        legal     = is_legal(bus.req_size, bus.req_addr);
        push      = handshake && legal;
        pop       = !empty && bus.mem_ready;
        enc_wdata = lane_data(bus.req_size, bus.req_data);
        enc_be    = lane_be(bus.req_size, bus.req_addr[1:0]);
    end

    // Outputs: head entry straight from storage, forced to zero while empty.
    always_comb begin
        bus.req_ready = ready;
        bus.req_err   = err_q;
        bus.buf_count = count;
        bus.buf_empty = empty;
        bus.mem_we    = !empty;
        bus.mem_addr  = empty ? 5'd0  : addr_q[rd_ptr];
        bus.mem_wdata = empty ? 32'd0 : wdata_q[rd_ptr];
        bus.mem_be    = empty ? 4'd0  : be_q[rd_ptr];
    end

    // Entry storage, written with the encoded store at enqueue.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr]  <= bus.req_addr[6:2];
            wdata_q[wr_ptr] <= enc_wdata;
            be_q[wr_ptr]    <= enc_be;
        end
    end

    // Pointers, occupancy and the one-cycle reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            err_q <= handshake && !legal;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer (DEPTH=4): a vector table for
// single-cycle behaviour plus hand sequences for fill/stall/stream and reset.
module tb_store_write_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    store_write_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mr;
        logic        we;
        logic [4:0]  maddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cnt;
        logic        err;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [1:0] s, logic [31:0] a, logic [31:0] d, logic mr,
                                logic we, logic [4:0] ma, logic [31:0] wd, logic [3:0] be,
                                int cnt, logic err, logic rdy);
        vec_t r;
        r.valid = v; r.size = s; r.addr = a; r.data = d; r.mr = mr;
        r.we = we; r.maddr = ma; r.wdata = wd; r.be = be; r.cnt = cnt; r.err = err; r.rdy = rdy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic we, input logic [4:0] ma,
                            input logic [31:0] wd, input logic [3:0] be, input int cnt,
                            input logic err, input logic rdy);
        chk({tag, ".mem_we"},    32'(bus.mem_we),    32'(we));
        chk({tag, ".mem_addr"},  32'(bus.mem_addr),  32'(ma));
        chk({tag, ".mem_wdata"}, bus.mem_wdata,      wd);
        chk({tag, ".mem_be"},    32'(bus.mem_be),    32'(be));
        chk({tag, ".buf_count"}, 32'(bus.buf_count), 32'(cnt));
        chk({tag, ".buf_empty"}, 32'(bus.buf_empty), 32'(cnt == 0));
        chk({tag, ".req_err"},   32'(bus.req_err),   32'(err));
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(rdy));
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic mr);
        bus.req_valid = v;
        bus.req_size  = s;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.mem_ready = mr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 5'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1);

        // Vector table: inputs applied before an edge, outputs expected after it
        tbl.push_back(mk(1, 2'b10, 32'h0C, 32'h28,       1, 1,  3, 32'h28,       4'hF, 1, 0, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 32'h05, 32'hAB,       0, 1,  1, 32'hABABABAB, 4'h2, 1, 0, 1));
        tbl.push_back(mk(1, 2'b01, 32'h0A, 32'h1234,     0, 1,  1, 32'hABABABAB, 4'h2, 2, 0, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 1,  2, 32'h12341234, 4'hC, 1, 0, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b01, 32'h03, 32'h55,       1, 0,  0, 32'h0,        4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b10, 32'h06, 32'h66,       1, 0,  0, 32'h0,        4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b11, 32'h00, 32'h77,       1, 0,  0, 32'h0,        4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b10, 32'h80, 32'h01,       1, 0,  0, 32'h0,        4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 32'h7F, 32'h12345678, 0, 1, 31, 32'h78787878, 4'h8, 1, 0, 1));
        tbl.push_back(mk(1, 2'b01, 32'h7E, 32'hCAFEBEEF, 1, 1, 31, 32'hBEEFBEEF, 4'hC, 1, 0, 1));
        tbl.push_back(mk(1, 2'b10, 32'h7C, 32'hDEADBEEF, 1, 1, 31, 32'hDEADBEEF, 4'hF, 1, 0, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b01, 32'h04, 32'h5A5A,     0, 1,  1, 32'h5A5A5A5A, 4'h3, 1, 0, 1));
        tbl.push_back(mk(0, 2'b00, 32'h00, 32'h00,       1, 0,  0, 32'h0,        4'h0, 0, 0, 1));

        // Release reset on a falling edge so the first vector meets the first rising edge
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].size, tbl[i].addr, tbl[i].data, tbl[i].mr);
            step();
            chk_outs($sformatf("vec%0d", i), tbl[i].we, tbl[i].maddr, tbl[i].wdata,
                     tbl[i].be, tbl[i].cnt, tbl[i].err, tbl[i].rdy);
            @(negedge clk);
        end

        // Fill with RAM stalled: words k=0..3 at address 4k, data 0x100+k
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'b10, 32'(4 * k), 32'(32'h100 + k), 1'b0);
            step();
            chk_outs($sformatf("fill%0d", k), 1'b1, 5'd0, 32'h100, 4'hF, k + 1, 1'b0, k < 3);
            @(negedge clk);
        end

        // Fifth store stalls while full
        drive(1'b1, 2'b10, 32'd16, 32'h104, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk_outs($sformatf("stall%0d", c), 1'b1, 5'd0, 32'h100, 4'hF, 4, 1'b0, 1'b0);
            @(negedge clk);
        end

        // RAM opens: full edge pops without pushing
        bus.mem_ready = 1'b1;
        step();
        chk_outs("open", 1'b1, 5'd1, 32'h101, 4'hF, 3, 1'b0, 1'b1);
        @(negedge clk);

        // Streaming: request k=n+2 before edge n; head k=n after it, count steady at 3
        for (int n = 2; n < 8; n++) begin
            drive(1'b1, 2'b10, 32'(4 * (n + 2)), 32'(32'h100 + n + 2), 1'b1);
            step();
            chk_outs($sformatf("stream%0d", n), 1'b1, 5'(n), 32'(32'h100 + n), 4'hF, 3, 1'b0, 1'b1);
            @(negedge clk);
        end

        // Drain the remaining words in order
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1);
        for (int n = 8; n < 10; n++) begin
            step();
            chk_outs($sformatf("drain%0d", n), 1'b1, 5'(n), 32'(32'h100 + n), 4'hF, 10 - n, 1'b0, 1'b1);
            @(negedge clk);
        end
        step();
        chk_outs("drained", 1'b0, 5'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1);
        @(negedge clk);

        // Reset with three entries pending
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b10, 32'(4 * k + 32), 32'(32'h200 + k), 1'b0);
            step();
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        chk("pending.buf_count", 32'(bus.buf_count), 32'd3);
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 5'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1);
        step();
        chk_outs("in_rst", 1'b0, 5'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_outs($sformatf("post_rst%0d", c), 1'b0, 5'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1);
            @(negedge clk);
        end

        // New store after reset proceeds normally
        drive(1'b1, 2'b10, 32'h10, 32'h77, 1'b1);
        step();
        chk_outs("after_rst", 1'b1, 5'd4, 32'h77, 4'hF, 1, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1);
        step();
        chk_outs("after_rst_idle", 1'b0, 5'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
